// File: rtl/box_slave_pkg.sv
// box_slave_pkg: shared widths, captured-slot layout and FSM encoding
// for the AXI3 write capture stage.
package box_slave_pkg;
    localparam int PDATA_WIDTH   = 32;
    localparam int PSTRB_WIDTH   = PDATA_WIDTH / 8;
    localparam int PLENGTH_WIDTH = 4;
    localparam int ID_WIDTH      = 4;
    localparam int ADDR_WIDTH    = 32;
    localparam int USER_WIDTH    = 4;
    localparam int MAX_BEATS     = 8;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_WIDTH-1:0]              awid;
        logic [ADDR_WIDTH-1:0]            awaddr;
        logic [PLENGTH_WIDTH-1:0]         awlen;
        logic [2:0]                       awsize;
        logic [1:0]                       awburst;
        logic [USER_WIDTH-1:0]            awuser;
        logic [MAX_BEATS*PDATA_WIDTH-1:0] data;
        logic [MAX_BEATS*PSTRB_WIDTH-1:0] strb;
    } spec_slot;

    typedef enum logic [1:0] {IDLE, DATA, HAND, RESP} box_slave_state_e;

    // Bursts that cannot fit the slot or use the reserved burst type
    function automatic logic aw_malformed(input logic [PLENGTH_WIDTH-1:0] len,
                                          input logic [1:0] burst);
        return (len > PLENGTH_WIDTH'(MAX_BEATS - 1)) || (burst == 2'b11);
    endfunction
endpackage

// File: rtl/axi_if.sv
// axi_if: AXI3 write address and write data channels as seen by the capture slave.
interface axi_if;
    import box_slave_pkg::*;
    logic [ID_WIDTH-1:0]      awid;
    logic [ADDR_WIDTH-1:0]    awaddr;
    logic [PLENGTH_WIDTH-1:0] awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic [USER_WIDTH-1:0]    awuser;
    logic                     awvalid;
    logic                     awready;
    logic [ID_WIDTH-1:0]      wid;
    logic [PDATA_WIDTH-1:0]   wdata;
    logic [PSTRB_WIDTH-1:0]   wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    modport slave_add  (input awid, awaddr, awlen, awsize, awburst, awuser, awvalid,
                        output awready);
    modport slave_data (input wid, wdata, wstrb, wlast, wvalid,
                        output wready);
endinterface

// File: rtl/box_beat_packer.sv
// box_beat_packer: saturating beat counter and per-lane data/strobe capture
// that packs W beats into the slot vectors.
module box_beat_packer
    import box_slave_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_clear,
    input  logic                             i_beat,
    input  logic                             i_store,
    input  logic [PDATA_WIDTH-1:0]           i_wdata,
    input  logic [PSTRB_WIDTH-1:0]           i_wstrb,
    output logic [PLENGTH_WIDTH-1:0]         o_beat,
    output logic [MAX_BEATS*PDATA_WIDTH-1:0] o_data,
    output logic [MAX_BEATS*PSTRB_WIDTH-1:0] o_strb
);
    localparam logic [PLENGTH_WIDTH-1:0] SAT = PLENGTH_WIDTH'(MAX_BEATS);

    logic [PLENGTH_WIDTH-1:0] r_beat;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_beat <= '0;
        else if (i_clear)
            r_beat <= '0;
        else if (i_beat && r_beat != SAT)
            r_beat <= r_beat + 1'b1;

    assign o_beat = r_beat;

    // A saturated counter matches no lane, so overflow beats are dropped
    for (genvar l = 0; l < MAX_BEATS; l++) begin : g_lane
        logic [PDATA_WIDTH-1:0] r_data;
        logic [PSTRB_WIDTH-1:0] r_strb;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                r_data <= '0;
                r_strb <= '0;
            end else if (i_clear) begin
                r_data <= '0;
                r_strb <= '0;
            end else if (i_beat && i_store && r_beat == PLENGTH_WIDTH'(l)) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
        assign o_data[l*PDATA_WIDTH +: PDATA_WIDTH] = r_data;
        assign o_strb[l*PSTRB_WIDTH +: PSTRB_WIDTH] = r_strb;
    end
endmodule

// File: rtl/box_slave.sv
// box_slave: captures one AXI3 write burst into a spec_slot, hands it downstream
// on tran_valid/tran_ready, then answers B; malformed bursts get SLVERR only.
module box_slave
    import box_slave_pkg::*;
#(
    parameter int WTIMEOUT = 255
)
(
    input  logic                clk,
    input  logic                rst_n,
    axi_if.slave_add            s_add,
    axi_if.slave_data           s_data,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                tran_valid,
    input  logic                tran_ready,
    output spec_slot            out_slot,
    output logic                ready_fall
);
    localparam int TW = 16;
    localparam logic [TW-1:0] TMO_LAST = TW'(WTIMEOUT - 1);

    box_slave_state_e          r_state;
    logic                      r_awready, r_wready, r_err;
    logic                      r_tran_valid, r_bvalid, r_ready_fall;
    logic [1:0]                r_bresp;
    logic [TW-1:0]             r_tmo;
    logic [ID_WIDTH-1:0]       r_awid;
    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic [PLENGTH_WIDTH-1:0]  r_awlen;
    logic [2:0]                r_awsize;
    logic [1:0]                r_awburst;
    logic [USER_WIDTH-1:0]     r_awuser;

    logic                             w_aw, w_beat, w_at_len, w_end, w_beat_err, w_tmo;
    logic [PLENGTH_WIDTH-1:0]         w_k;
    logic [MAX_BEATS*PDATA_WIDTH-1:0] w_data;
    logic [MAX_BEATS*PSTRB_WIDTH-1:0] w_strb;

    assign w_aw       = s_add.awvalid & r_awready;
    assign w_beat     = s_data.wvalid & r_wready;
    assign w_at_len   = (w_k == r_awlen);
    assign w_end      = w_beat & (s_data.wlast | w_at_len);
    // wlast must coincide exactly with beat awlen: early and late both flag
    assign w_beat_err = (s_data.wid != r_awid) | (s_data.wlast ^ w_at_len);
    assign w_tmo      = (WTIMEOUT != 0) && !w_beat && (r_tmo == TMO_LAST);

    box_beat_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_aw),
        .i_beat  (w_beat),
        .i_store (!r_err),
        .i_wdata (s_data.wdata),
        .i_wstrb (s_data.wstrb),
        .o_beat  (w_k),
        .o_data  (w_data),
        .o_strb  (w_strb)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state      <= IDLE;
            r_awready    <= 1'b1;
            r_wready     <= 1'b0;
            r_err        <= 1'b0;
            r_tran_valid <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= BRESP_OKAY;
            r_ready_fall <= 1'b0;
            r_tmo        <= '0;
            r_awid       <= '0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awsize     <= '0;
            r_awburst    <= '0;
            r_awuser     <= '0;
        end else begin
            r_ready_fall <= 1'b0;
            case (r_state)
                IDLE: if (w_aw) begin
                    r_awid    <= s_add.awid;
                    r_awaddr  <= s_add.awaddr;
                    r_awlen   <= s_add.awlen;
                    r_awsize  <= s_add.awsize;
                    r_awburst <= s_add.awburst;
                    r_awuser  <= s_add.awuser;
                    r_err     <= aw_malformed(s_add.awlen, s_add.awburst);
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_tmo     <= '0;
                    r_state   <= DATA;
                end
                DATA: begin
                    r_tmo <= w_beat ? '0 : r_tmo + 1'b1;
                    if (w_beat)
                        r_err <= r_err | w_beat_err;
                    if (w_end || w_tmo) begin
                        r_wready <= 1'b0;
                        if (w_end && !(r_err | w_beat_err)) begin
                            r_tran_valid <= 1'b1;
                            r_state      <= HAND;
                        end else begin
                            r_err    <= 1'b1;
                            r_bvalid <= 1'b1;
                            r_bresp  <= BRESP_SLVERR;
                            r_state  <= RESP;
                        end
                    end
                end
                HAND: if (tran_ready) begin
                    r_tran_valid <= 1'b0;
                    r_ready_fall <= 1'b1;
                    r_bvalid     <= 1'b1;
                    r_bresp      <= BRESP_OKAY;
                    r_state      <= RESP;
                end
                RESP: if (bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end

    assign s_add.awready = r_awready;
    assign s_data.wready = r_wready;
    assign bid           = r_awid;
    assign bresp         = r_bresp;
    assign bvalid        = r_bvalid;
    assign tran_valid    = r_tran_valid;
    assign ready_fall    = r_ready_fall;
    assign out_slot      = '{awid: r_awid, awaddr: r_awaddr, awlen: r_awlen,
                             awsize: r_awsize, awburst: r_awburst, awuser: r_awuser,
                             data: w_data, strb: w_strb};
endmodule

// File: tb/tb_box_slave.sv
// tb_box_slave: randomized scoreboard bench; a burst-level model predicts the
// B response and forwarded slot, a monitor pops and compares on each handshake.
module tb_box_slave;
    import box_slave_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bready = 1'b0;
    logic tran_ready = 1'b0;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0] bresp;
    logic bvalid, tran_valid, ready_fall;
    spec_slot out_slot;

    axi_if ax();

    always #5 clk = ~clk;

    box_slave #(.WTIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .s_add(ax), .s_data(ax),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .tran_valid(tran_valid), .tran_ready(tran_ready),
        .out_slot(out_slot), .ready_fall(ready_fall)
    );

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } bexp_t;

    bexp_t    bq[$];
    spec_slot sq[$];
    bexp_t    mon_e;
    int checks = 0;
    int failures = 0;
    int bdone = 0;
    bit auto_rdy = 1'b0;
    bit prev_hs = 1'b0;

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s act=none exp=event", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) prev_hs = 1'b0;
        else begin
            if (ready_fall || prev_hs) chk("ready_fall", ready_fall, prev_hs);
            prev_hs = tran_valid && tran_ready;
            if (tran_valid && tran_ready) begin
                if (sq.size() == 0) miss("slot_unexpected");
                else chk("slot", out_slot, sq.pop_front());
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) miss("b_unexpected");
                else begin
                    mon_e = bq.pop_front();
                    chk("bid", bid, mon_e.id);
                    chk("bresp", bresp, mon_e.resp);
                end
                bdone++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_rdy) begin
            tran_ready = 1'($urandom_range(0, 1));
            bready     = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_reset();
        chk("rst_awready", ax.awready, 1'b1);
        chk("rst_wready", ax.wready, 1'b0);
        chk("rst_tran_valid", tran_valid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_bid", bid, '0);
        chk("rst_ready_fall", ready_fall, 1'b0);
        chk("rst_slot", out_slot, '0);
    endtask

    task automatic send_aw(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [PLENGTH_WIDTH-1:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [USER_WIDTH-1:0] user);
        ax.awid = id; ax.awaddr = addr; ax.awlen = len;
        ax.awburst = burst; ax.awsize = size; ax.awuser = user;
        ax.awvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ax.awready) break;
        end
        if (!ax.awready) miss("aw_accept");
        @(posedge clk);
        #1;
        ax.awvalid = 1'b0;
    endtask

    task automatic send_w(input int gap, input logic [ID_WIDTH-1:0] id,
                          input logic [PDATA_WIDTH-1:0] d, input logic [PSTRB_WIDTH-1:0] st,
                          input bit last);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        ax.wid = id; ax.wdata = d; ax.wstrb = st; ax.wlast = last;
        ax.wvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ax.wready) break;
        end
        if (!ax.wready) miss("w_accept");
        @(posedge clk);
        #1;
        ax.wvalid = 1'b0;
        ax.wlast = 1'b0;
    endtask

    task automatic wait_b(input int target);
        for (int t = 0; t < 400 && bdone < target; t++) @(negedge clk);
        if (bdone < target) miss("b_handshake");
        @(posedge clk);
        #1;
    endtask

    // mode: 0 clean, 1 early wlast at beat e, 2 wlast never, 3 bad wid at beat e, 4 W stops before beat e
    task automatic run_burst(input int mode, input logic [ID_WIDTH-1:0] id,
                             input logic [ADDR_WIDTH-1:0] addr, input logic [PLENGTH_WIDTH-1:0] len,
                             input logic [1:0] burst, input int e, input bit fixed);
        spec_slot s;
        logic [PDATA_WIDTH-1:0] q_d[$];
        logic [PSTRB_WIDTH-1:0] q_s[$];
        logic [ID_WIDTH-1:0]    q_i[$];
        bit                     q_l[$];
        int                     q_g[$];
        logic [2:0]             size;
        logic [USER_WIDTH-1:0]  user;
        logic [PDATA_WIDTH-1:0] d;
        logic [PSTRB_WIDTH-1:0] st;
        logic [ID_WIDTH-1:0]    wi;
        bit err, tmo, wl, at_len;
        int k;
        size = 3'($urandom_range(0, 2));
        user = USER_WIDTH'($urandom);
        s = '0;
        s.awid = id; s.awaddr = addr; s.awlen = len;
        s.awsize = size; s.awburst = burst; s.awuser = user;
        err = (int'(len) >= MAX_BEATS) || (burst == 2'b11);
        tmo = 1'b0;
        for (int i = 0; i < 2 * MAX_BEATS; i++) begin
            if (mode == 4 && i == e) begin
                tmo = 1'b1;
                err = 1'b1;
                break;
            end
            k = (i < MAX_BEATS) ? i : MAX_BEATS;
            at_len = (k == int'(len));
            wl = (mode == 1) ? (i == e) : (mode == 2) ? 1'b0 : (i == int'(len));
            wi = (mode == 3 && i == e) ? id ^ ID_WIDTH'(1) : id;
            d  = fixed ? PDATA_WIDTH'(32'hA0 + i) : PDATA_WIDTH'($urandom);
            st = fixed ? {PSTRB_WIDTH{1'b1}} : PSTRB_WIDTH'($urandom);
            if (!err && k < MAX_BEATS) begin
                s.data[k*PDATA_WIDTH +: PDATA_WIDTH] = d;
                s.strb[k*PSTRB_WIDTH +: PSTRB_WIDTH] = st;
            end
            if (wi != id || (wl && !at_len) || (at_len && !wl)) err = 1'b1;
            q_d.push_back(d); q_s.push_back(st); q_i.push_back(wi); q_l.push_back(wl);
            q_g.push_back(fixed ? 0 : int'($urandom_range(0, 2)));
            if (wl || at_len) break;
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        if (!err) sq.push_back(s);
        send_aw(id, addr, len, burst, size, user);
        foreach (q_d[j]) send_w(q_g[j], q_i[j], q_d[j], q_s[j], q_l[j]);
        if (tmo) begin
            for (int c = 0; c < TMO; c++) begin
                @(negedge clk);
                chk("wready_idle", ax.wready, 1'b1);
            end
            @(negedge clk);
            chk("wready_tmo", ax.wready, 1'b0);
            chk("bvalid_tmo", bvalid, 1'b1);
        end else begin
            @(negedge clk);
            chk("tran_valid_end", tran_valid, !err);
            chk("bvalid_end", bvalid, err);
            chk("wready_end", ax.wready, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, mode, e;
        logic [PLENGTH_WIDTH-1:0] len;
        logic [1:0] burst;
        ax.awvalid = 1'b0;
        ax.wvalid = 1'b0;
        ax.wlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tran_ready = 1'b1;
        bready = 1'b1;
        n = bdone;
        run_burst(0, 4'd3, 32'h100, 4'd3, 2'b01, 0, 1'b1);
        wait_b(n + 1);

        tran_ready = 1'b0;
        n = bdone;
        run_burst(0, 4'd7, 32'h240, 4'd0, 2'b01, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", tran_valid, 1'b1);
            chk("hold_slot", out_slot, sq.size() > 0 ? sq[0] : '0);
            chk("hold_awready", ax.awready, 1'b0);
        end
        @(posedge clk);
        #1;
        tran_ready = 1'b1;
        wait_b(n + 1);

        n = bdone;
        run_burst(1, 4'd5, 32'h300, 4'd3, 2'b01, 2, 1'b0);
        wait_b(n + 1);

        n = bdone;
        run_burst(0, 4'd6, 32'h400, 4'(MAX_BEATS), 2'b01, 0, 1'b0);
        wait_b(n + 1);
        chk("oversize_data_zero", out_slot.data, '0);

        n = bdone;
        run_burst(3, 4'd2, 32'h500, 4'd1, 2'b01, 1, 1'b0);
        wait_b(n + 1);

        n = bdone;
        run_burst(4, 4'd1, 32'h600, 4'd3, 2'b01, 0, 1'b0);
        wait_b(n + 1);

        bready = 1'b0;
        send_aw(4'd9, 32'h700, 4'd3, 2'b01, 3'd2, 4'd0);
        send_w(0, 4'd9, 32'h11, 4'hF, 1'b0);
        send_w(0, 4'd9, 32'h22, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bready = 1'b1;
        n = bdone;
        run_burst(0, 4'd10, 32'h800, 4'd3, 2'b01, 0, 1'b0);
        wait_b(n + 1);

        auto_rdy = 1'b1;
        repeat (40) begin
            mode = int'($urandom_range(0, 4));
            len = (mode == 0 && $urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                : (mode == 1) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 7));
            e = (mode == 1) ? int'($urandom_range(0, int'(len) - 1)) : int'($urandom_range(0, int'(len)));
            burst = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            n = bdone;
            run_burst(mode, ID_WIDTH'($urandom), ADDR_WIDTH'($urandom), len, burst, e, 1'b0);
            wait_b(n + 1);
        end
        auto_rdy = 1'b0;
        repeat (3) @(posedge clk);
        chk("slot_queue_drained", sq.size(), 0);
        chk("b_queue_drained", bq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/box_slave.md
Name: box_slave

Overview:
AXI3 write-slave capture stage that sits directly upstream of the transaction master stage in the box.
- Accepts one write burst at a time on the slave address and data channels.
- Packs the data beats into a single spec_slot.
- Hands the slot downstream on a tran_valid/tran_ready handshake, then issues the B response.
- Malformed or oversized bursts are absorbed and answered with SLVERR; they are never forwarded.

Parameters:
- WTIMEOUT, 255, idle cycles allowed between W beats while in DATA before the burst is aborted with SLVERR; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_add  axi_if.slave_add  -  awid/awaddr/awlen/awsize/awburst/awuser/awvalid in, awready out
- s_data  axi_if.slave_data  -  wid/wdata/wstrb/wlast/wvalid in, wready out
- bid  output  ID_WIDTH  response ID (the captured awid)
- bresp  output  2  0b00 OKAY, 0b10 SLVERR
- bvalid  output  1  response valid
- bready  input  1  response accept
- tran_valid  output  1  captured slot is valid for the downstream master stage
- tran_ready  input  1  downstream stage can take a slot
- out_slot  output  spec_slot  captured transaction
- ready_fall  output  1  one-cycle pulse, cycle after slot handoff; starts downstream AW issue

Behaviour:
Reset values:
- awready=1, wready=0, tran_valid=0, bvalid=0, bresp=0, bid=0, ready_fall=0.
- out_slot all zeros; FSM in IDLE.

FSM states: IDLE, DATA, HAND, RESP.

IDLE:
- awready=1.
- On awvalid&awready (cycle N): latch all AW fields into out_slot, zero out_slot.data and out_slot.strb, clear beat counter and err flag.
- Set err if awlen > MAX_BEATS-1 or awburst==2'b11.
- Go to DATA: awready=0 and wready=1 from N+1.

DATA:
- wready=1.
- Each wvalid&wready beat k (k = beat counter, PLENGTH_WIDTH bits, no wrap):
  - If no err: store wdata into data[k*PDATA_WIDTH +: PDATA_WIDTH] and wstrb into strb[k*PSTRB_WIDTH +: PSTRB_WIDTH].
  - Increment the counter, saturating at MAX_BEATS.
- Error conditions, each setting err:
  - wid != latched awid, checked per beat
  - wlast with k != awlen (early)
  - beat k == awlen without wlast (late)
- The burst ends on the beat with wlast, or on the beat k==awlen, whichever comes first.
- End of burst at cycle M: wready=0 from M+1; go to HAND if !err, otherwise RESP with SLVERR.
- Timeout counter resets on every beat. When it reaches WTIMEOUT: set err, wready=0, go to RESP.

HAND:
- tran_valid=1; out_slot is stable.
- On tran_valid&tran_ready (cycle H): tran_valid=0 and ready_fall=1 at H+1 for exactly one cycle.
- Go to RESP with OKAY.
- tran_ready held high before entry: handoff completes on the first HAND cycle.

RESP:
- bvalid=1, bid=awid, bresp per err.
- On bvalid&bready: bvalid=0, awready=1 next cycle, back to IDLE.

Throughput and latency:
- Exactly one outstanding burst; no AW is accepted from DATA through RESP.
- Minimum latency: AW accepted at N, single beat accepted at N+1, tran_valid at N+2.

Slot contents:
- out_slot holds its value after handoff until the next AW accept, so the downstream stage may keep reading data during its burst.
- Unused beat lanes read as zero.

Reset mid-operation:
- Any state returns to IDLE with reset values.
- The partial slot is discarded; no B response and no ready_fall.

Decomposition:
pkg holds:
- PDATA_WIDTH, PSTRB_WIDTH=PDATA_WIDTH/8, PLENGTH_WIDTH, ID_WIDTH, MAX_BEATS
- spec_slot struct: awid, awaddr, awlen, awsize, awburst, awuser, data[MAX_BEATS*PDATA_WIDTH], strb[MAX_BEATS*PSTRB_WIDTH]
- box_slave_state_e enum
- BRESP_OKAY, BRESP_SLVERR

Sub-module box_beat_packer: beat-counter plus lane-write logic, with inputs beat/wdata/wstrb/clear; output data/strb vectors.

Test Plan:
- AW awid=3 awaddr=0x100 awlen=3, 4 beats 0xA0..0xA3 with wlast on 4th, tran_ready=1 -> tran_valid 1 cycle after 4th beat; slot.data lanes 0..3=A0..A3, lanes 4+ zero; ready_fall 1-cycle pulse; bresp=OKAY bid=3.
- awlen=0, single beat, tran_ready=0 for 5 cycles -> tran_valid held 5 cycles with slot stable; awready stays 0; handoff then bvalid.
- awlen=3 with wlast on beat 2 -> SLVERR; no tran_valid; no ready_fall; next AW accepted after bready.
- awlen=MAX_BEATS -> all beats accepted and discarded; SLVERR; out_slot.data remains zero.
- wid mismatch on beat 1 of 2, and separately no W for WTIMEOUT=8 cycles -> SLVERR; in the timeout case wready drops after 8 idle cycles.
- rst_n asserted mid-DATA after 2 of 4 beats -> all outputs at reset values; following clean burst completes with OKAY.
